// File: rtl/parity_pkg.sv
// Shared definitions for the frame parity unit: FSM state encoding,
// mode constants and the count-width helper.
package parity_pkg;

    // FSM states; encoding 2'd3 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Frame mode, sampled on the first word of each frame.
    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Width needed to hold a word count from 0 up to max_words inclusive.
    function automatic int cw_of(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of one data word to a single parity bit.
// This is the WIDTH-input generalisation of the 3-input odd-function gate.
module parity_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    // Fold all bits of the word with XOR.
    function automatic logic xor_fold(input logic [WIDTH-1:0] v);
        logic p;
        p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            p = p ^ v[i];
        end
        return p;
    endfunction

    assign parity = xor_fold(data);

endmodule

// File: rtl/parity_frame_unit.sv
// Frame parity unit: accepts WIDTH-bit words over valid/ready, accumulates
// one parity bit per frame (closed by In_last or by reaching MAX_WORDS) and
// presents the result, held until consumed. In check mode the result is
// compared against the parity bit supplied with the closing word.
module parity_frame_unit
    import parity_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  MAX_WORDS = 16,
    parameter bit  ODD       = 1'b0,
    localparam int CW        = cw_of(MAX_WORDS)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] In_data,
    input  logic             In_last,
    input  logic             Mode,
    input  logic             In_par,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic             Out_parity,
    output logic             Out_error,
    output logic             Out_ovf,
    output logic [CW-1:0]    Out_count
);

    // Per-word parity from the reduction sub-module.
    logic          word_par_s;

    // Frame state and accumulators.
    state_e        state_r;
    logic          acc_r;
    logic [CW-1:0] count_r;
    logic          mode_r;

    // Output registers; In_ready is registered too and mirrors state != DONE.
    logic          ready_r;
    logic          valid_r;
    logic          parity_r;
    logic          error_r;
    logic          ovf_r;
    logic [CW-1:0] out_count_r;

    // Next-value terms for the beat being accepted this cycle.
    logic          beat_s;
    logic          acc_next_s;
    logic [CW-1:0] count_next_s;
    logic          mode_eff_s;
    logic          at_max_s;
    logic          close_s;
    logic          err_next_s;

    parity_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .data   (In_data),
        .parity (word_par_s)
    );

    // Compute accumulator, count and error as they would be after a beat now.
    always_comb begin
        beat_s = In_valid & ready_r;
        case (state_r)
            S_IDLE: begin
                // First word of a frame: load accumulator, take Mode directly.
                acc_next_s   = word_par_s;
                count_next_s = CW'(1);
                mode_eff_s   = Mode;
            end
            S_ACCUM: begin
                acc_next_s   = acc_r ^ word_par_s;
                count_next_s = count_r + CW'(1);
                mode_eff_s   = mode_r;
            end
            default: begin
                acc_next_s   = acc_r;
                count_next_s = count_r;
                mode_eff_s   = mode_r;
            end
        endcase
        at_max_s   = (count_next_s == CW'(MAX_WORDS));
        close_s    = In_last | at_max_s;
        err_next_s = (In_par != (acc_next_s ^ ODD)) & (mode_eff_s == MODE_CHK);
    end

    // Frame FSM with accumulator, counter and registered result outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= S_IDLE;
            acc_r       <= 1'b0;
            count_r     <= '0;
            mode_r      <= MODE_GEN;
            ready_r     <= 1'b1;
            valid_r     <= 1'b0;
            parity_r    <= 1'b0;
            error_r     <= 1'b0;
            ovf_r       <= 1'b0;
            out_count_r <= '0;
        end else begin
            case (state_r)
                S_IDLE, S_ACCUM: begin
                    if (beat_s) begin
                        acc_r   <= acc_next_s;
                        count_r <= count_next_s;
                        if (state_r == S_IDLE) begin
                            mode_r <= Mode;
                        end
                        if (close_s) begin
                            // Closing beat: latch the result; a last on the
                            // MAX_WORDS beat is a normal close, not overflow.
                            state_r     <= S_DONE;
                            ready_r     <= 1'b0;
                            valid_r     <= 1'b1;
                            parity_r    <= acc_next_s ^ ODD;
                            error_r     <= err_next_s;
                            ovf_r       <= ~In_last;
                            out_count_r <= count_next_s;
                        end else begin
                            state_r <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    // Result held until taken; no new beat in the same cycle.
                    if (Out_ready) begin
                        state_r <= S_IDLE;
                        ready_r <= 1'b1;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    // Unused encoding: drop any partial frame and restart.
                    state_r <= S_IDLE;
                    acc_r   <= 1'b0;
                    count_r <= '0;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign In_ready   = ready_r;
    assign Out_valid  = valid_r;
    assign Out_parity = parity_r;
    assign Out_error  = error_r;
    assign Out_ovf    = ovf_r;
    assign Out_count  = out_count_r;

endmodule

// File: tb/tb_parity_frame_unit.sv
// Self-checking bench for parity_frame_unit (WIDTH=8, MAX_WORDS=4).
// Two instances share the stimulus: one with even parity, one with odd.
// Expected results come from a word-list model: parity is the count of ones
// modulo 2, the count is the list length, overflow is a close without last.
module tb_parity_frame_unit;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 4;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    logic             Clock = 1'b0;
    logic             Reset;
    logic             In_valid;
    logic [WIDTH-1:0] In_data;
    logic             In_last;
    logic             Mode;
    logic             In_par;
    logic             Out_ready;

    logic             In_ready, Out_valid, Out_parity, Out_error, Out_ovf;
    logic [CW-1:0]    Out_count;
    logic             odd_ready, odd_valid, odd_parity, odd_error, odd_ovf;
    logic [CW-1:0]    odd_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] words[$];
    bit         m_mode;
    bit         exp_par;
    bit         exp_err_even;
    bit         exp_err_odd;
    bit         exp_ovf;
    int         exp_cnt;

    always #5 Clock = ~Clock;

    parity_frame_unit #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS), .ODD(1'b0)) dut (
        .Clock(Clock), .Reset(Reset), .In_valid(In_valid), .In_ready(In_ready),
        .In_data(In_data), .In_last(In_last), .Mode(Mode), .In_par(In_par),
        .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_parity(Out_parity),
        .Out_error(Out_error), .Out_ovf(Out_ovf), .Out_count(Out_count)
    );

    parity_frame_unit #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS), .ODD(1'b1)) dut_odd (
        .Clock(Clock), .Reset(Reset), .In_valid(In_valid), .In_ready(odd_ready),
        .In_data(In_data), .In_last(In_last), .Mode(Mode), .In_par(In_par),
        .Out_valid(odd_valid), .Out_ready(Out_ready), .Out_parity(odd_parity),
        .Out_error(odd_error), .Out_ovf(odd_ovf), .Out_count(odd_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Result registers of both instances against the model's expectation.
    task automatic check_outputs(input string tag);
        check({tag, "_valid"},     Out_valid,  1);
        check({tag, "_ready"},     In_ready,   0);
        check({tag, "_parity"},    Out_parity, exp_par);
        check({tag, "_error"},     Out_error,  exp_err_even);
        check({tag, "_ovf"},       Out_ovf,    exp_ovf);
        check({tag, "_count"},     Out_count,  exp_cnt);
        check({tag, "_odd_valid"}, odd_valid,  1);
        check({tag, "_odd_par"},   odd_parity, !exp_par);
        check({tag, "_odd_err"},   odd_error,  exp_err_odd);
        check({tag, "_odd_ovf"},   odd_ovf,    exp_ovf);
        check({tag, "_odd_cnt"},   odd_count,  exp_cnt);
    endtask

    // Offer one word, wait (bounded) for acceptance, update the model.
    task automatic do_beat(input logic [7:0] d, input bit last, input bit m,
                           input bit p, output bit closed);
        int waited;
        int ones;
        waited   = 0;
        In_valid = 1'b1;
        In_data  = d;
        In_last  = last;
        Mode     = m;
        In_par   = p;
        while (!In_ready && waited < 16) begin
            tick();
            waited++;
        end
        if (!In_ready) check("ready_timeout", 0, 1);
        words.push_back(d);
        if (words.size() == 1) m_mode = m;
        closed = last || (words.size() == MAX_WORDS);
        if (closed) begin
            ones = 0;
            foreach (words[i]) ones += $countones(words[i]);
            exp_par      = bit'(ones % 2);
            exp_cnt      = words.size();
            exp_ovf      = !last;
            exp_err_even = m_mode & (p != exp_par);
            exp_err_odd  = m_mode & (p != !exp_par);
            check("valid_before_close", Out_valid, 0);
        end
        tick();
        In_valid = 1'b0;
        In_data  = 8'($urandom);
        In_last  = 1'($urandom);
        Mode     = 1'($urandom);
        In_par   = 1'($urandom);
        if (closed) begin
            words.delete();
            check_outputs("close");
        end else begin
            check("mid_valid", Out_valid, 0);
            check("mid_ready", In_ready, 1);
        end
    endtask

    // Hold the result for a number of cycles, then take it.
    task automatic consume(input int hold);
        repeat (hold) begin
            tick();
            check_outputs("hold");
        end
        Out_ready = 1'b1;
        tick();
        Out_ready = 1'b0;
        check("consumed_valid", Out_valid, 0);
        check("consumed_ready", In_ready, 1);
        check("consumed_odd_valid", odd_valid, 0);
    endtask

    initial begin
        bit closed;
        Reset = 1'b1; In_valid = 1'b0; In_data = 8'h00; In_last = 1'b0;
        Mode = 1'b0; In_par = 1'b0; Out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        check("rst_valid",  Out_valid,  0);
        check("rst_parity", Out_parity, 0);
        check("rst_error",  Out_error,  0);
        check("rst_ovf",    Out_ovf,    0);
        check("rst_count",  Out_count,  0);
        check("rst_ready",  In_ready,   1);
        check("rst_odd_parity", odd_parity, 0);

        // Single word, generate mode
        do_beat(8'hA5, 1'b1, 1'b0, 1'b0, closed);
        consume(0);

        // Three words with idle gaps between beats
        do_beat(8'h01, 1'b0, 1'b0, 1'b0, closed);
        repeat (2) begin tick(); check("gap_ready", In_ready, 1); check("gap_valid", Out_valid, 0); end
        do_beat(8'h02, 1'b0, 1'b1, 1'b1, closed);
        tick();
        do_beat(8'h07, 1'b1, 1'b1, 1'b1, closed);
        consume(1);

        // Check mode with mismatching and matching expected parity
        do_beat(8'hFF, 1'b1, 1'b1, 1'b1, closed);
        consume(0);
        do_beat(8'hFF, 1'b1, 1'b1, 1'b0, closed);
        consume(0);

        // Overflow, then a fifth word held off until the result is taken
        repeat (4) do_beat(8'h01, 1'b0, 1'b0, 1'b0, closed);
        check("ovf_closed", closed, 1);
        In_valid = 1'b1; In_data = 8'h01; In_last = 1'b1; Mode = 1'b0;
        repeat (2) begin
            tick();
            check("fifth_ready", In_ready, 0);
            check("fifth_count", Out_count, 4);
            check("fifth_ovf", Out_ovf, 1);
        end
        Out_ready = 1'b1;
        tick();
        Out_ready = 1'b0;
        check("fifth_idle_valid", Out_valid, 0);
        check("fifth_idle_ready", In_ready, 1);
        tick();
        In_valid = 1'b0;
        check("fifth_valid", Out_valid, 1);
        check("fifth_count1", Out_count, 1);
        check("fifth_parity", Out_parity, 1);
        check("fifth_ovf0", Out_ovf, 0);
        consume(0);

        // Backpressure for 3 cycles
        do_beat(8'h3C, 1'b0, 1'b1, 1'b1, closed);
        do_beat(8'h81, 1'b1, 1'b0, 1'b0, closed);
        consume(3);

        // Reset in the middle of a frame discards it
        do_beat(8'h03, 1'b0, 1'b0, 1'b0, closed);
        do_beat(8'h03, 1'b0, 1'b0, 1'b0, closed);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        words.delete();
        repeat (3) begin
            tick();
            check("rst_mid_valid", Out_valid, 0);
            check("rst_mid_ready", In_ready, 1);
        end
        do_beat(8'h80, 1'b1, 1'b0, 1'b0, closed);
        consume(0);

        // Randomized frames with gaps, overflow and backpressure
        for (int f = 0; f < 40; f++) begin
            int  n;
            bit  use_last;
            int  i;
            n        = int'($urandom_range(1, MAX_WORDS));
            use_last = ($urandom_range(0, 3) != 0);
            i        = 0;
            closed   = 1'b0;
            while (!closed) begin
                do_beat(8'($urandom), use_last && (i == n - 1),
                        1'($urandom), 1'($urandom), closed);
                i++;
                if (!closed) repeat ($urandom_range(0, 2)) tick();
            end
            consume(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
